// File: rtl/multi_clock_divider.sv
// NUM_CH independent programmable clock dividers with run, single-step and
// glitch-free divisor reprogramming. All outputs are flops fed by next-state values.
module multi_clock_divider #(
    parameter int               NUM_CH      = 2,
    parameter int               WIDTH       = 28,
    parameter int               CH_BITS     = 1,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(28'd5000000)
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     en,
    input  logic [NUM_CH-1:0]     step,
    input  logic                  cfg_we,
    input  logic [CH_BITS-1:0]    cfg_ch,
    input  logic [WIDTH-1:0]      cfg_div,
    output logic [NUM_CH-1:0]     clk_out,
    output logic [NUM_CH-1:0]     tick,
    output logic [NUM_CH-1:0]     busy,
    output logic [2*NUM_CH-1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_e;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        state_e           state_q, state_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] div_q, div_d;
        logic [WIDTH-1:0] pend_q, pend_d;
        logic             pend_v_q, pend_v_d;
        logic             step_q;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             wr_hit;
        logic             step_rise;
        logic             wrap;
        logic [WIDTH-1:0] last_q;
        logic [WIDTH-1:0] eff_d;

        // A divisor of 0 behaves as 1, so the terminal count is 0 in both cases.
        assign last_q    = (div_q == '0) ? '0 : div_q - WIDTH'(1);
        assign wrap      = (cnt_q == last_q);
        assign wr_hit    = cfg_we && (cfg_ch == CH_BITS'(ch));
        assign step_rise = step[ch] & ~step_q;

        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            div_d    = div_q;
            pend_d   = pend_q;
            pend_v_d = pend_v_q;
            clk_d    = 1'b0;
            tick_d   = 1'b0;
            eff_d    = WIDTH'(1);

            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (wr_hit) div_d = cfg_div;
                    if (en[ch])         state_d = RUN;
                    else if (step_rise) state_d = STEP;
                end
                RUN, STEP: begin
                    if (wr_hit) begin
                        pend_d   = cfg_div;
                        pend_v_d = 1'b1;
                    end
                    if (state_q == RUN && !en[ch]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
                        if (state_q == STEP) begin
                            if (en[ch])    state_d = RUN;
                            else if (wrap) state_d = IDLE;
                        end
                    end
                    // Divisor changes only at a period boundary or when the channel stops.
                    if (wrap || state_d == IDLE) begin
                        if (pend_v_d) div_d = pend_d;
                        pend_v_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase

            eff_d = (div_d == '0) ? WIDTH'(1) : div_d;
            if (state_d != IDLE) begin
                clk_d  = (cnt_d >= (eff_d >> 1));
                tick_d = (cnt_d == eff_d - WIDTH'(1));
            end
        end

        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                div_q    <= DEFAULT_DIV;
                pend_q   <= '0;
                pend_v_q <= 1'b0;
                step_q   <= 1'b0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                div_q    <= div_d;
                pend_q   <= pend_d;
                pend_v_q <= pend_v_d;
                step_q   <= step[ch];
                clk_q    <= clk_d;
                tick_q   <= tick_d;
            end
        end

        assign clk_out[ch]           = clk_q;
        assign tick[ch]              = tick_q;
        assign busy[ch]              = (state_q != IDLE);
        assign dbg_state[2*ch +: 2]  = state_q;
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Bench for multi_clock_divider: directed literal sequences plus randomized
// traffic checked every cycle against a period-level channel model.
module tb_multi_clock_divider;

    localparam int               NUM_CH  = 2;
    localparam int               WIDTH   = 8;
    localparam int               CH_BITS = 2;
    localparam logic [WIDTH-1:0] DEF_DIV = 8'd4;

    logic                 clk_in;
    logic                 rst_n;
    logic [NUM_CH-1:0]    en;
    logic [NUM_CH-1:0]    step;
    logic                 cfg_we;
    logic [CH_BITS-1:0]   cfg_ch;
    logic [WIDTH-1:0]     cfg_div;
    logic [NUM_CH-1:0]    clk_out;
    logic [NUM_CH-1:0]    tick;
    logic [NUM_CH-1:0]    busy;
    logic [2*NUM_CH-1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    multi_clock_divider #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH), .CH_BITS(CH_BITS), .DEFAULT_DIV(DEF_DIV)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .en(en), .step(step),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .clk_out(clk_out), .tick(tick), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    // Each channel: mode 0=stopped, 1=free running, 2=single period;
    // pos = position inside the current period.
    int m_mode[NUM_CH];
    int m_pos[NUM_CH];
    int m_div[NUM_CH];
    int m_pend[NUM_CH];
    bit m_pv[NUM_CH];
    bit m_prev[NUM_CH];

    function automatic int period_of(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    always @(posedge clk_in or negedge rst_n) begin : mdl
        bit rise, wr, last;
        int per;
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_mode[c] = 0; m_pos[c] = 0; m_div[c] = int'(DEF_DIV);
                m_pend[c] = 0; m_pv[c] = 1'b0; m_prev[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                rise = step[c] && !m_prev[c];
                m_prev[c] = step[c];
                wr = cfg_we && (int'(cfg_ch) == c);
                per = period_of(m_div[c]);
                last = (m_pos[c] == per - 1);
                if (m_mode[c] == 0) begin
                    if (wr) m_div[c] = int'(cfg_div);
                    if (en[c]) begin m_mode[c] = 1; m_pos[c] = 0; end
                    else if (rise) begin m_mode[c] = 2; m_pos[c] = 0; end
                end else begin
                    if (wr) begin m_pend[c] = int'(cfg_div); m_pv[c] = 1'b1; end
                    if (m_mode[c] == 1 && !en[c]) begin
                        m_mode[c] = 0; m_pos[c] = 0;
                    end else begin
                        m_pos[c] = last ? 0 : m_pos[c] + 1;
                        if (m_mode[c] == 2) m_mode[c] = en[c] ? 1 : (last ? 0 : 2);
                    end
                    if ((last || m_mode[c] == 0) && m_pv[c]) begin
                        m_div[c] = m_pend[c]; m_pv[c] = 1'b0;
                    end
                end
            end
        end
    end

    function automatic logic exp_clk(input int c);
        if (m_mode[c] == 0) return 1'b0;
        return m_pos[c] >= period_of(m_div[c]) / 2;
    endfunction

    function automatic logic exp_tick(input int c);
        if (m_mode[c] == 0) return 1'b0;
        return m_pos[c] == period_of(m_div[c]) - 1;
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Every negative edge: DUT outputs against the model.
    always @(negedge clk_in) begin
        for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("model_clk_out[%0d]", c), clk_out[c], exp_clk(c));
            chk($sformatf("model_tick[%0d]", c),    tick[c],    exp_tick(c));
            chk($sformatf("model_busy[%0d]", c),    busy[c],    logic'(m_mode[c] != 0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int d);
        cfg_we = 1'b1; cfg_ch = CH_BITS'(ch); cfg_div = WIDTH'(d);
        cyc();
        cfg_we = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] p_clk, p_tick, p_busy;

    initial begin
        rst_n = 1'b0; en = '0; step = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
        #3;
        for (int c = 0; c < NUM_CH; c++) begin
            chk("reset_clk_out", clk_out[c], 1'b0);
            chk("reset_tick",    tick[c],    1'b0);
            chk("reset_busy",    busy[c],    1'b0);
        end
        @(posedge clk_in); #1;
        rst_n = 1'b1;

        // Default divisor 4 from reset.
        en[0] = 1'b1;
        p_clk = 16'b1100_1100; p_tick = 16'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("run4_clk",  clk_out[0], p_clk[i]);
            chk("run4_tick", tick[0],    p_tick[i]);
            chk("run4_busy", busy[0],    1'b1);
        end
        en[0] = 1'b0;
        cyc();
        chk("stop_clk",  clk_out[0], 1'b0);
        chk("stop_busy", busy[0],    1'b0);

        // Odd divisor on ch1.
        cfg_write(1, 5);
        en[1] = 1'b1;
        p_clk = 16'b11100_11100; p_tick = 16'b10000_10000;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("div5_clk",  clk_out[1], p_clk[i]);
            chk("div5_tick", tick[1],    p_tick[i]);
        end
        en[1] = 1'b0;
        cyc();

        // Degenerate divisors 0 and 1.
        for (int d = 0; d < 2; d++) begin
            cfg_write(1, d);
            en[1] = 1'b1;
            for (int i = 0; i < 5; i++) begin
                cyc();
                chk($sformatf("div%0d_clk", d),  clk_out[1], 1'b1);
                chk($sformatf("div%0d_tick", d), tick[1],    1'b1);
            end
            en[1] = 1'b0;
            cyc();
        end

        // Reprogram 8 -> 2: mid-period write, then a write on the wrap edge.
        p_clk = 16'b1010_1111_0000; p_tick = 16'b1010_1000_0000;
        for (int w = 0; w < 2; w++) begin
            cfg_write(0, 8);
            en[0] = 1'b1;
            for (int i = 0; i < 12; i++) begin
                cyc();
                chk($sformatf("reprog%0d_clk", w),  clk_out[0], p_clk[i]);
                chk($sformatf("reprog%0d_tick", w), tick[0],    p_tick[i]);
                if (i == (w == 0 ? 3 : 7)) begin
                    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2;
                end
                if (i == (w == 0 ? 4 : 8)) cfg_we = 1'b0;
            end
            en[0] = 1'b0;
            cyc();
        end

        // Single step, div 6, 3-cycle pulse plus an ignored second pulse.
        cfg_write(0, 6);
        step[0] = 1'b1;
        p_clk = 16'b00_0011_1000; p_tick = 16'b00_0010_0000; p_busy = 16'b00_0011_1111;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("step_clk",  clk_out[0], p_clk[i]);
            chk("step_tick", tick[0],    p_tick[i]);
            chk("step_busy", busy[0],    p_busy[i]);
            if (i == 2) step[0] = 1'b0;
            if (i == 3) step[0] = 1'b1;
            if (i == 4) step[0] = 1'b0;
        end

        // Step, then en mid-period (no restart), then en drop mid-period.
        step[0] = 1'b1;
        p_busy = 16'b00_1111_1111;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("step_run_clk",  clk_out[0], p_clk[i]);
            chk("step_run_tick", tick[0],    p_tick[i]);
            chk("step_run_busy", busy[0],    p_busy[i]);
            if (i == 0) step[0] = 1'b0;
            if (i == 2) en[0] = 1'b1;
            if (i == 7) en[0] = 1'b0;
        end

        // Out-of-range channel write leaves both divisors (6 and 1) alone.
        cfg_write(3, 2);
        en = 2'b11;
        p_tick = 16'b10_0000;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("badch_tick0", tick[0], p_tick[i]);
            chk("badch_tick1", tick[1], 1'b1);
        end
        en = '0;
        cyc();

        // Async reset mid-period with a pending write.
        cfg_write(0, 4);
        en[0] = 1'b1;
        cyc(); cyc();
        cfg_write(0, 2);
        chk("pre_rst_clk", clk_out[0], 1'b1);
        #2; rst_n = 1'b0; #1;
        chk("async_rst_clk",  clk_out[0], 1'b0);
        chk("async_rst_tick", tick[0],    1'b0);
        chk("async_rst_busy", busy[0],    1'b0);
        en = '0;
        #2; rst_n = 1'b1;
        cyc();
        en[0] = 1'b1;
        p_clk = 16'b1100_1100; p_tick = 16'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("post_rst_clk",  clk_out[0], p_clk[i]);
            chk("post_rst_tick", tick[0],    p_tick[i]);
        end
        en = '0;
        cyc();

        // Randomized traffic, checked by the per-cycle model compare.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 19) == 0) en[c] = ~en[c];
                if ($urandom_range(0, 3) == 0)  step[c] = ~step[c];
            end
            cfg_we  = ($urandom_range(0, 9) == 0);
            cfg_ch  = CH_BITS'($urandom_range(0, 3));
            cfg_div = ($urandom_range(0, 4) == 0) ? WIDTH'($urandom_range(0, 40))
                                                  : WIDTH'($urandom_range(0, 9));
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0; #2; rst_n = 1'b1;
            end
        end
        cfg_we = 1'b0; en = '0; step = '0;
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
Parametrised successor to the single fixed-divisor clock divider. Provides NUM_CH independent divided-clock channels from one system clock. Each channel has a runtime-programmable divisor, a registered square-wave output and a one-cycle tick output. Each channel also has a single-step mode, so the CPU core can be clocked one period at a time for debug. Sits between the board oscillator and the CPU/peripheral clock enables.

Parameters:
NUM_CH, 2, number of independent divider channels (1..16)
WIDTH, 28, divisor/counter width in bits
CH_BITS, 1, width of channel select (must satisfy 2**CH_BITS >= NUM_CH)
DEFAULT_DIV, 28'd5000000, divisor loaded into every channel at reset; f(clk_out) = f(clk_in)/div

Ports:
clk_in  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  NUM_CH  per-channel run enable (level)
step  input  NUM_CH  per-channel single-step request (rising-edge detected internally)
cfg_we  input  1  divisor write strobe, one cycle
cfg_ch  input  CH_BITS  channel written by cfg_we
cfg_div  input  WIDTH  new divisor value
clk_out  output  NUM_CH  divided square wave per channel, registered
tick  output  NUM_CH  one-cycle pulse per period, registered
busy  output  NUM_CH  channel is in RUN or STEP

Behaviour:
- Reset (async, rst_n=0): all states IDLE, cnt=0, div=DEFAULT_DIV, pending cleared, step edge-detect flops=0. clk_out, tick and busy = 0.
- Per-channel state machine:
  - IDLE: cnt held at 0; clk_out=0, tick=0.
  - IDLE -> RUN on the edge sampling en=1. IDLE -> STEP on the edge sampling a step rising edge while en=0. en has priority.
  - RUN: cnt increments each edge and wraps div-1 -> 0. RUN -> IDLE on the edge sampling en=0; cnt is forced to 0 on that edge.
  - STEP: counts like RUN for exactly one period. STEP -> IDLE on the edge where cnt==div-1. STEP -> RUN if en=1 is sampled; count continues without restart.
  - Step rising edges in RUN or STEP are ignored and are not queued.
- Outputs are flops, valid in the same cycle as cnt (computed from next-state values):
  - In RUN or STEP: clk_out = (cnt >= div>>1); tick = (cnt == div-1).
  - Zero latency relative to the counter; no combinational path from inputs to outputs.
- Divisor rules:
  - Effective divisor 0 is treated as 1.
  - div=1: cnt stays 0; clk_out and tick are constantly 1 while RUN.
  - Odd div: low phase = div>>1 cycles, high phase = div - (div>>1) cycles.
- Divisor write:
  - cfg_we with cfg_ch >= NUM_CH is ignored.
  - Target channel IDLE: div is updated on that edge.
  - Target channel RUN/STEP: the value goes to a pending register and is applied on the next wrap edge (cnt==div-1 -> 0), so there are no runt pulses.
  - Write on the same edge as a wrap: the written value is applied at that wrap.
  - Multiple writes before a wrap: last write wins.
- Channels are fully independent; simultaneous en/step/cfg events on different channels do not interact.
- Reset asserted mid-period: outputs drop to 0 asynchronously; pending writes are discarded.

Test Plan:
- Reset and run, DEFAULT_DIV=4: release rst_n, en[0]=1 at edge E0 -> cnt 0,1,2,3,0 on E0..E4; clk_out[0]=1 after E2 and E3 only; tick[0]=1 only after E3; busy[0]=1 from E0.
- Odd and degenerate divisors: write div=5 to idle ch1, then run -> 2 cycles low, 3 high, tick period 5. Write div=0 and div=1 -> clk_out[1] and tick[1] constantly 1 while en=1.
- Glitch-free reprogram: ch0 running div=8, write div=2 at cnt=3 -> current period completes all 8 cycles, then period 2. Write landing exactly on the cnt=7 edge -> next period is 2.
- Single step: en[0]=0, div=6, 3-cycle-wide step pulse -> exactly one period (3 low, 3 high, one tick), then IDLE with busy=0. A second step pulse during STEP produces no extra period.
- Mixed control: step then en=1 mid-period -> continues into RUN without a restart. en=0 mid-period -> clk_out=0, cnt=0 on the next edge. cfg_ch=3 with NUM_CH=2 -> no divisor changes.
- Async reset mid-run (cnt=2, div=4) -> clk_out/tick/busy=0 immediately without a clock edge; after release, div=DEFAULT_DIV and the pending write is gone.
